// File: rtl/pq_pkg.sv
// Shared types for the array priority queue: cell layout and the engine FSM states.
package pq_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ID_WIDTH   = 3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } cell_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pq_state_e;
endpackage

// File: rtl/pq_skid_buf.sv
// Two-entry FIFO of queue cells; entry 0 is the registered head presented downstream.
module pq_skid_buf
  import pq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cell_t      din,
  output cell_t      dout,
  output logic [1:0] cnt
);
  cell_t e0, e1;

  assign dout = e0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: shift when full, otherwise replace the departing head.
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pq_pop_reader.sv
// Read-side engine: pops qualifying queue heads into a skid buffer, streams them out
// and hands each delivered id back to the allocator.
module pq_pop_reader
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = pq_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = pq_pkg::ID_WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] thr_i,
  input  logic                  pq_empty_i,
  input  cell_t                 pq_head_i,
  output logic                  pq_pop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output cell_t                 out_cell_o,
  output logic                  id_free_valid_o,
  output logic [ID_WIDTH-1:0]   id_free_o,
  output logic                  idle_o,
  output logic [CNT_W-1:0]      pop_cnt_o
);
  pq_state_e  state, state_nxt;
  logic [1:0] cnt;
  logic       fire;

  pq_skid_buf u_buf (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (pq_pop_o),
    .pop  (fire),
    .din  (pq_head_i),
    .dout (out_cell_o),
    .cnt  (cnt)
  );

  assign out_valid_o = (cnt != 2'd0);
  assign fire        = out_valid_o && out_ready_i;
  // A full buffer still accepts a pop when its head leaves in the same cycle.
  assign pq_pop_o    = (state == RUN) && !pq_empty_i && (pq_head_i.data >= thr_i) &&
                       ((cnt != 2'd2) || fire);
  assign idle_o      = (state == IDLE) && (cnt == 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = RUN;
      RUN:     if (!en_i) state_nxt = DRAIN;
      DRAIN: begin
        if (en_i)                state_nxt = RUN;
        else if (cnt == 2'd0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_free_valid_o <= 1'b0;
      id_free_o       <= '0;
      pop_cnt_o       <= '0;
    end else begin
      id_free_valid_o <= fire;
      if (fire) begin
        id_free_o <= out_cell_o.id;
        pop_cnt_o <= pop_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pq_pop_reader.sv
// Random-stimulus bench: the bench plays the priority queue and tracks delivery with queues.
module tb_pq_pop_reader;
  import pq_pkg::*;

  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            en_i;
  logic [15:0]     thr_i;
  logic            pq_empty_i;
  cell_t           pq_head_i;
  logic            pq_pop_o;
  logic            out_valid_o;
  logic            out_ready_i;
  cell_t           out_cell_o;
  logic            id_free_valid_o;
  logic [2:0]      id_free_o;
  logic            idle_o;
  logic [CW-1:0]   pop_cnt_o;

  always #5 clk = ~clk;

  pq_pop_reader #(.DATA_WIDTH(16), .ID_WIDTH(3), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .thr_i          (thr_i),
    .pq_empty_i     (pq_empty_i),
    .pq_head_i      (pq_head_i),
    .pq_pop_o       (pq_pop_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_cell_o     (out_cell_o),
    .id_free_valid_o(id_free_valid_o),
    .id_free_o      (id_free_o),
    .idle_o         (idle_o),
    .pop_cnt_o      (pop_cnt_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: mode 0=stopped, 1=popping, 2=finishing buffered cells.
  int    mode;
  cell_t src_q[$];
  cell_t buf_q[$];
  int    ndel;
  bit    exp_fv;
  logic [2:0] exp_fid;

  function automatic cell_t rnd_cell();
    cell_t c;
    c.data = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
    c.id   = 3'($urandom_range(0, 7));
    return c;
  endfunction

  task automatic drive_head();
    pq_empty_i = (src_q.size() == 0);
    pq_head_i  = (src_q.size() != 0) ? src_q[0] : rnd_cell();
  endtask

  task automatic model_reset();
    mode   = 0;
    buf_q  = {};
    ndel   = 0;
    exp_fv = 1'b0;
  endtask

  bit exp_pop, fire, do_rst;
  int nxt;

  initial begin
    rst_i = 1'b1; en_i = 1'b0; thr_i = '0; out_ready_i = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_cell());
    drive_head();
    #12;
    chk("rst_pop",   pq_pop_o, 0);
    chk("rst_idle",  idle_o, 1);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_fv",    id_free_valid_o, 0);
    chk("rst_cnt",   pop_cnt_o, 0);
    chk("rst_cell",  out_cell_o, 0);
    @(negedge clk); rst_i = 1'b0;
    #1;
    chk("post_rst_pop",  pq_pop_o, 0);
    chk("post_rst_idle", idle_o, 1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_i = 1'b0;
      if ($urandom_range(0, 19) == 0) en_i = ~en_i;
      if ($urandom_range(0, 9) == 0)
        thr_i = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 10));
      out_ready_i = ($urandom_range(0, 9) < 7);
      if (src_q.size() < 4 && $urandom_range(0, 2) != 0) src_q.push_back(rnd_cell());
      drive_head();
      #1;
      fire    = (buf_q.size() != 0) && out_ready_i;
      exp_pop = (mode == 1) && (src_q.size() != 0) && (src_q[0].data >= thr_i) &&
                (buf_q.size() < 2 || fire);
      chk("pop",   pq_pop_o, exp_pop);
      chk("valid", out_valid_o, buf_q.size() != 0);
      if (buf_q.size() != 0) chk("cell", out_cell_o, buf_q[0]);
      chk("idle",  idle_o, (mode == 0) && (buf_q.size() == 0));
      chk("fv",    id_free_valid_o, exp_fv);
      if (exp_fv) chk("fid", id_free_o, exp_fid);
      chk("pcnt",  pop_cnt_o, ndel % (1 << CW));

      do_rst = (cyc % 700 == 350);
      if (do_rst) begin
        #2 rst_i = 1'b1;
        #1;
        chk("arst_pop",   pq_pop_o, 0);
        chk("arst_valid", out_valid_o, 0);
        chk("arst_fv",    id_free_valid_o, 0);
        chk("arst_cnt",   pop_cnt_o, 0);
        chk("arst_idle",  idle_o, 1);
        @(posedge clk);
        model_reset();
        continue;
      end

      @(posedge clk);
      case (mode)
        0:       nxt = en_i ? 1 : 0;
        1:       nxt = en_i ? 1 : 2;
        default: nxt = en_i ? 1 : ((buf_q.size() == 0) ? 0 : 2);
      endcase
      mode   = nxt;
      exp_fv = fire;
      if (fire) begin
        exp_fid = buf_q[0].id;
        void'(buf_q.pop_front());
        ndel++;
      end
      if (exp_pop) buf_q.push_back(src_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pq_pop_reader.md
Name: pq_pop_reader

Overview:
- Read-side engine for the array priority queue.
- Pops the head cell (data, id) from the queue whenever downstream has room and the head priority meets a programmable threshold.
- Buffers popped cells in a 2-entry skid buffer and delivers them on a valid/ready stream.
- Returns each delivered id to the id allocator, so queue ids can be reused.

Parameters:
- DATA_WIDTH, pq_pkg::DATA_WIDTH (16): width of the priority/data field.
- ID_WIDTH, pq_pkg::ID_WIDTH (3): width of the cell id.
- CNT_W, 16: width of the delivered-cell statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  enable popping; deasserting starts a drain.
- thr_i  in  DATA_WIDTH  pop only when head data >= thr_i.
- pq_empty_i  in  1  queue holds no cells.
- pq_head_i  in  cell_t  current queue head; valid when !pq_empty_i.
- pq_pop_o  out  1  pop strobe; queue removes head at this edge.
- out_valid_o  out  1  stream valid.
- out_ready_i  in  1  stream ready.
- out_cell_o  out  cell_t  stream payload.
- id_free_valid_o  out  1  one-cycle pulse; id returned to allocator.
- id_free_o  out  ID_WIDTH  id being freed.
- idle_o  out  1  state==IDLE and buffer empty.
- pop_cnt_o  out  CNT_W  count of delivered cells, wraps.

Behaviour:
- Reset values: state=IDLE, buffer count=0, pq_pop_o=0, out_valid_o=0, out_cell_o='0, id_free_valid_o=0, id_free_o=0, idle_o=1, pop_cnt_o=0.
- Reset is asynchronous. Asserting it mid-operation discards buffered cells without freeing their ids; the allocator is reset by the same rst_i.
- FSM states:
  - IDLE -> RUN when en_i=1.
  - RUN -> DRAIN when en_i=0.
  - DRAIN -> IDLE when buffer count=0.
  - DRAIN -> RUN when en_i=1 again.
- pq_pop_o (combinational) = state==RUN && !pq_empty_i && pq_head_i.data >= thr_i && (cnt<2 || fire).
  - fire = out_valid_o && out_ready_i.
  - Comparison is unsigned, full DATA_WIDTH.
  - Pop never occurs in IDLE or DRAIN.
- On a pop edge, pq_head_i is captured into the buffer tail in the same cycle. Pop-to-out_valid latency is 1 cycle.
- The queue presents its new head the cycle after a pop. Back-to-back pops every cycle are legal, giving a sustained throughput of 1 cell/cycle with out_ready_i=1.
- Buffer: 2 entries, FIFO order.
  - out_valid_o = cnt!=0.
  - out_cell_o = entry 0, registered and held stable while valid && !ready.
- Simultaneous pop and fire at cnt=2: entry 1 shifts to 0 and the new cell goes to entry 1; cnt stays 2.
- Simultaneous pop and fire at cnt=1: cnt stays 1 and the new cell becomes entry 0.
- Fire pulses:
  - On each fire, the next cycle has id_free_valid_o=1 and id_free_o=fired id (registered, 1-cycle latency).
  - pop_cnt_o increments on each fire and wraps 2^CNT_W-1 -> 0.
- Threshold change takes effect in the same cycle. Cells already buffered are always delivered, even if below the new threshold.
- pq_empty_i=1 means no pop. pq_head_i is ignored when empty.
- idle_o = state==IDLE && cnt==0, combinational.

Decomposition:
- pq_pkg: cell_t, DATA_WIDTH, ID_WIDTH. Add the FSM enum typedef (IDLE, RUN, DRAIN) to the package for reuse by the write side.
- One sub-module: pq_skid_buf. 2-entry cell_t FIFO with push/pop/count, same async active-high reset.

Test Plan:
- Reset check: after reset with en_i=0 and a non-empty queue -> pq_pop_o=0, idle_o=1, out_valid_o=0.
- Continuous streaming: en_i=1, thr_i=0, queue holds heads data=9/id=1, data=5/id=2, data=3/id=0, out_ready_i=1 -> pops on 3 consecutive cycles; out_cell_o yields (9,1),(5,2),(3,0) on consecutive cycles; id_free pulses 1,2,0 one cycle later; pop_cnt_o=3.
- Threshold: thr_i=6, heads (9,1) then (5,2) -> only (9,1) popped; pq_pop_o stays 0 while head data=5. Raising the head to 7 -> pop resumes the same cycle.
- Backpressure: out_ready_i=0, 3 cells queued -> exactly 2 pops, then pq_pop_o=0 and out_cell_o stable. Releasing ready for 1 cycle -> that fire and a pop occur in the same cycle, cnt stays 2.
- Drain: cnt=2, then en_i drops -> no further pops, both buffered cells delivered, state returns to IDLE and idle_o=1 after the second fire.
- Async reset: rst_i asserted mid-stream, away from a clock edge -> out_valid_o, pq_pop_o and id_free_valid_o fall immediately; pop_cnt_o=0.
